lockstep_commit_checker: RTL and testbench

// Consumer side of the dual-core harness: receives per-instruction commit records from the golden
// (single-cycle) core and the segmented (pipelined) core and checks they retire the same sequence.

---
 rtl/lockstep_commit_checker.sv | 151 +++++++++++++++
 tb/tb_lockstep_commit_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_commit_checker.sv
// Lockstep commit checker: buffers golden commits, compares them in order against segmented-core commits.
// Latency: 1 cycle from s_valid to the registered mismatch/fail/fail_code/fail_pc outputs.
// Backpressure: none; a full buffer drops the golden commit and raises an error. CHECKER_CONTINUE_EN keeps running after field mismatches.
module lockstep_commit_checker #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    g_valid,
    input  logic [PC_W-1:0]         g_pc,
    input  logic                    g_we,
    input  logic [4:0]              g_rd,
    input  logic [DATA_W-1:0]       g_data,
    input  logic                    s_valid,
    input  logic [PC_W-1:0]         s_pc,
    input  logic                    s_we,
    input  logic [4:0]              s_rd,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    fail,
    output logic [1:0]              fail_code,
    output logic [PC_W-1:0]         fail_pc,
    output logic                    mismatch,
    output logic [31:0]             commit_count,
    output logic [15:0]             error_count,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } commit_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAIL} state_t;

    state_t        state, state_nxt;
    commit_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] to_cnt, to_nxt;
    commit_t       g_dat, s_dat, head_dat, ref_dat;
    logic          active, empty, full, bypass, pop, push;
    logic          fields_ok, spurious, field_err, overflow, to_hit;
    logic          err_vld, stop_err, match_ok;
    logic [1:0]    err_code;
    logic [PC_W-1:0] err_pc;

    assign g_dat    = {g_pc, g_we, g_rd, g_data};
    assign s_dat    = {s_pc, s_we, s_rd, s_data};
    assign head_dat = mem[rd_ptr];
    assign active   = (state != ST_FAIL);
    assign empty    = (fifo_level == '0);
    assign full     = (fifo_level == FULL_LVL);

    // An empty buffer lets a same-cycle golden commit be checked directly without being stored.
    assign bypass   = active & s_valid & empty & g_valid;
    assign ref_dat  = empty ? g_dat : head_dat;
    assign fields_ok = (ref_dat.pc == s_dat.pc) && (ref_dat.we == s_dat.we) &&
                       (!ref_dat.we || (ref_dat.rd == 5'd0) ||
                        ((ref_dat.rd == s_dat.rd) && (ref_dat.data == s_dat.data)));

    assign pop       = active & s_valid & ~empty;
    assign push      = active & g_valid & ~bypass & (~full | pop);
    assign spurious  = active & s_valid & empty & ~g_valid;
    assign field_err = active & s_valid & ~spurious & ~fields_ok;
    assign match_ok  = active & s_valid & ~spurious & fields_ok;
    assign overflow  = active & g_valid & full & ~s_valid;
    assign to_hit    = active & ~s_valid & ~empty & ((to_cnt + TW'(1)) == TO_LIM);
    assign err_vld   = field_err | spurious | overflow | to_hit;

    always_comb begin
        err_code  = 2'd3;
        err_pc    = head_dat.pc;
        to_nxt    = to_cnt;
        state_nxt = state;
        if (field_err) begin
            err_code = 2'd1;
            err_pc   = s_pc;
        end else if (spurious) begin
            err_code = 2'd2;
            err_pc   = s_pc;
        end else if (overflow) begin
            err_pc   = g_pc;
        end
        if (active) begin
            to_nxt = (s_valid || empty) ? '0 : to_cnt + TW'(1);
        end
`ifdef CHECKER_CONTINUE_EN
        stop_err = spurious | overflow | to_hit;
`else
        stop_err = err_vld;
`endif
        case (state)
            ST_IDLE: begin
                if (stop_err)                state_nxt = ST_FAIL;
                else if (g_valid || s_valid) state_nxt = ST_RUN;
            end
            ST_RUN:  if (stop_err) state_nxt = ST_FAIL;
            default: state_nxt = ST_FAIL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= g_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            to_cnt       <= '0;
            fail         <= 1'b0;
            fail_code    <= 2'd0;
            fail_pc      <= '0;
            mismatch     <= 1'b0;
            commit_count <= '0;
            error_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            to_cnt     <= to_nxt;
            mismatch   <= err_vld;
            if (match_ok) commit_count <= commit_count + 32'd1;
            if (err_vld && (error_count != 16'hFFFF)) error_count <= error_count + 16'd1;
            // Only the first divergence is recorded; later errors are only counted.
            if (err_vld && !fail) begin
                fail      <= 1'b1;
                fail_code <= err_code;
                fail_pc   <= err_pc;
            end
        end
    end
endmodule

// File: tb/tb_lockstep_commit_checker.sv
// Bench for lockstep_commit_checker: queue-based reference of the commit-matching rules,
// directed scenarios with literal expectations, then randomized commit streams.
module tb_lockstep_commit_checker;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        g_valid = 1'b0, s_valid = 1'b0;
    logic [31:0] g_pc = '0, s_pc = '0, g_data = '0, s_data = '0;
    logic        g_we = 1'b0, s_we = 1'b0;
    logic [4:0]  g_rd = '0, s_rd = '0;
    logic        fail, mismatch;
    logic [1:0]  fail_code;
    logic [31:0] fail_pc, commit_count;
    logic [15:0] error_count;
    logic [3:0]  fifo_level;

    int tests = 0;
    int fails = 0;

    lockstep_commit_checker #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .g_valid(g_valid), .g_pc(g_pc), .g_we(g_we), .g_rd(g_rd), .g_data(g_data),
        .s_valid(s_valid), .s_pc(s_pc), .s_we(s_we), .s_rd(s_rd), .s_data(s_data),
        .fail(fail), .fail_code(fail_code), .fail_pc(fail_pc), .mismatch(mismatch),
        .commit_count(commit_count), .error_count(error_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    // Reference state: outstanding golden commits and the expected output values.
    rec_t        mq[$];
    rec_t        sq[$];
    logic        m_fail, m_mis, m_stop;
    logic [1:0]  m_code;
    logic [31:0] m_pc, m_cnt;
    logic [15:0] m_err;
    int          m_idle;

    function automatic rec_t mk(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                                input logic [31:0] data);
        rec_t r;
        r.pc = pc; r.we = we; r.rd = rd; r.data = data;
        return r;
    endfunction

    function automatic bit same_commit(input rec_t gr, input rec_t sr);
        if (gr.pc != sr.pc || gr.we != sr.we) return 1'b0;
        if (!gr.we || gr.rd == 5'd0) return 1'b1;
        return (gr.rd == sr.rd) && (gr.data == sr.data);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fail = 0; m_mis = 0; m_stop = 0; m_code = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_idle = 0;
    endtask

    task automatic model_step();
        rec_t gr, sr, r, head;
        bit have, used_g, was_empty, err;
        logic [1:0]  code;
        logic [31:0] epc;
        m_mis = 0;
        if (!reset || m_stop) return;
        gr = mk(g_pc, g_we, g_rd, g_data);
        sr = mk(s_pc, s_we, s_rd, s_data);
        have = 0; used_g = 0; err = 0; code = 0; epc = 0;
        r = gr; head = gr;
        was_empty = (mq.size() == 0);
        if (!was_empty) head = mq[0];
        if (s_valid) begin
            if (!was_empty) begin
                r = mq.pop_front(); have = 1;
            end else if (g_valid) begin
                r = gr; have = 1; used_g = 1;
            end else begin
                err = 1; code = 2; epc = s_pc;
            end
            if (have) begin
                if (same_commit(r, sr)) m_cnt = m_cnt + 1;
                else begin err = 1; code = 1; epc = s_pc; end
            end
        end
        if (g_valid && !used_g) begin
            if (mq.size() < DEPTH) mq.push_back(gr);
            else if (!err) begin err = 1; code = 3; epc = g_pc; end
        end
        if (s_valid || was_empty) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TIMEOUT && !err) begin err = 1; code = 3; epc = head.pc; end
        end
        if (err) begin
            m_mis = 1;
            if (m_err != 16'hFFFF) m_err = m_err + 1;
            if (!m_fail) begin m_fail = 1; m_code = code; m_pc = epc; end
`ifdef CHECKER_CONTINUE_EN
            if (code != 2'd1) m_stop = 1;
`else
            m_stop = 1;
`endif
        end
    endtask

    task automatic compare_all();
        check("fail", fail, m_fail);
        check("fail_code", fail_code, m_code);
        check("fail_pc", fail_pc, m_pc);
        check("mismatch", mismatch, m_mis);
        check("commit_count", commit_count, m_cnt);
        check("error_count", error_count, m_err);
        check("fifo_level", fifo_level, 64'(mq.size()));
    endtask

    // Inputs change on the falling edge; the DUT and the reference both sample on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit gv, input rec_t gr, input bit sv, input rec_t sr);
        g_valid = gv; g_pc = gr.pc; g_we = gr.we; g_rd = gr.rd; g_data = gr.data;
        s_valid = sv; s_pc = sr.pc; s_we = sr.we; s_rd = sr.rd; s_data = sr.data;
    endtask

    task automatic idle_tick();
        g_valid = 0; s_valid = 0;
        tick();
    endtask

    task automatic do_reset();
        g_valid = 0; s_valid = 0;
        reset = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        reset = 1;
    endtask

    rec_t z, a, b;
    int   peak;
    logic [31:0] pc_ctr;

    initial begin
        z = mk(0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Four buffered golden commits, then the same four from the segmented core.
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, mk(32'(i * 4), 1, 1, 32'(i)), 0, z); tick();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        idle_tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, z, 1, mk(32'(i * 4), 1, 1, 32'(i))); tick();
        end
        check("t2_commit_count", commit_count, 4);
        check("t2_fail", fail, 0);
        check("t2_peak_level", 64'(peak), 4);

        // Reset in the middle of a run with three commits buffered.
        for (int i = 0; i < 3; i++) begin
            drive(1, mk(32'h20 + 32'(i * 4), 1, 2, 32'(i)), 0, z); tick();
        end
        check("t1_level_before", fifo_level, 3);
        do_reset();
        check("t1_level", fifo_level, 0);
        check("t1_fail", fail, 0);
        check("t1_commit_count", commit_count, 0);

        // Same-cycle commits on an empty buffer are checked directly.
        a = mk(32'h10, 1, 3, 32'hAA);
        drive(1, a, 1, a); tick();
        check("t3_commit_count", commit_count, 1);
        check("t3_level", fifo_level, 0);
        check("t3_fail", fail, 0);

        // Writeback data mismatch.
        do_reset();
        drive(1, mk(32'h8, 1, 1, 32'hAA), 0, z); tick();
        drive(0, z, 1, mk(32'h8, 1, 1, 32'hAB)); tick();
        check("t4_mismatch", mismatch, 1);
        check("t4_fail_code", fail_code, 1);
        check("t4_fail_pc", fail_pc, 32'h8);
        idle_tick();
        check("t4_mismatch_pulse", mismatch, 0);
        a = mk(32'hC, 1, 1, 32'h1);
        drive(1, a, 0, z); tick();
        drive(0, z, 1, a); tick();
`ifdef CHECKER_CONTINUE_EN
        check("t4_continue_count", commit_count, 1);
`else
        check("t4_stopped_count", commit_count, 0);
`endif
        check("t4_fail_kept", fail_code, 1);

        // Writes to r0 compare only pc/we; then an unmatched segmented commit.
        do_reset();
        drive(1, mk(32'h30, 1, 0, 32'h5), 0, z); tick();
        drive(0, z, 1, mk(32'h30, 1, 0, 32'h9)); tick();
        check("t5_rd0_count", commit_count, 1);
        check("t5_rd0_fail", fail, 0);
        drive(0, z, 1, mk(32'h34, 1, 4, 32'h1)); tick();
        check("t5_spurious_code", fail_code, 2);
        check("t5_spurious_pc", fail_pc, 32'h34);
        check("t5_err_count", error_count, 1);

        // Golden commit left unmatched until the timeout.
        do_reset();
        drive(1, mk(32'h40, 1, 5, 32'h7), 0, z); tick();
        for (int i = 0; i < TIMEOUT - 1; i++) idle_tick();
        check("t6_no_fail_yet", fail, 0);
        idle_tick();
        check("t6_fail_code", fail_code, 3);
        check("t6_fail_pc", fail_pc, 32'h40);
        check("t6_err_count", error_count, 1);

        // Full buffer: push with pop is accepted, push alone overflows.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, mk(32'h100 + 32'(i * 4), 1, 2, 32'(i)), 0, z); tick();
        end
        check("t7_full_level", fifo_level, DEPTH);
        drive(1, mk(32'h120, 1, 2, 32'h8), 1, mk(32'h100, 1, 2, 32'h0)); tick();
        check("t7_pushpop_level", fifo_level, DEPTH);
        check("t7_pushpop_count", commit_count, 1);
        check("t7_pushpop_fail", fail, 0);
        drive(1, mk(32'h124, 1, 2, 32'h9), 0, z); tick();
        check("t7_ovf_code", fail_code, 3);
        check("t7_ovf_pc", fail_pc, 32'h124);

        // Randomized streams: segmented core replays golden commits with random lag and rare corruption.
        pc_ctr = 32'h1000;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            sq.delete();
            for (int n = 0; n < 400; n++) begin
                bit gv, sv, byp;
                gv = ($urandom_range(99) < 50) && (sq.size() < DEPTH || $urandom_range(49) == 0);
                a = mk(pc_ctr, 1'($urandom_range(1)),
                       ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31)), $urandom);
                pc_ctr = pc_ctr + 4;
                sv = 0;
                if (sq.size() > 0 || gv) sv = ($urandom_range(99) < 45);
                else if (r >= 3) sv = ($urandom_range(99) == 0);
                byp = sv && (sq.size() == 0) && gv;
                b = (sq.size() > 0) ? sq[0] : a;
                if (sv && r > 0 && $urandom_range(199) < r) begin
                    case ($urandom_range(2))
                        0: b.pc = b.pc ^ 32'h4;
                        1: b.data = b.data ^ 32'h1;
                        default: b.rd = b.rd ^ 5'h1;
                    endcase
                end
                if (sv && sq.size() > 0) void'(sq.pop_front());
                if (gv && !byp) sq.push_back(a);
                drive(gv, a, sv, b);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
